fifo_sync_prog: RTL and testbench

//  Single-clock synchronous FIFO, next generation of the team's basic FIFO. Adds programmable

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_ram.sv | 22 ++
 rtl/fifo_sync_prog.sv | 129 ++++++++++++
 tb/tb_fifo_sync_prog.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the programmable synchronous FIFO family.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit in_range(input int unsigned val, input int unsigned lo,
                                  input int unsigned hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with occupancy count, programmable almost flags, flush, error pulses and
// selectable standard / first-word-fall-through read mode.
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_THRESH  = 28,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Flush,
  input  logic                  Write_EN,
  input  logic [DATA_WIDTH-1:0] Data_IN,
  input  logic                  Read_EN,
  output logic [DATA_WIDTH-1:0] Data_OUT,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_Full,
  output logic                  Almost_Empty,
  output logic                  OverFlow,
  output logic                  UnderFlow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0] CntFull  = CntW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AfullThr = CntW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AemptThr = CntW'(AEMPTY_THRESH);

  if (!in_range(AFULL_THRESH, 1, DEPTH)) begin : g_chk_afull
    $error("AFULL_THRESH out of range 1..DEPTH");
  end
  if (!in_range(AEMPTY_THRESH, 0, DEPTH - 1)) begin : g_chk_aempty
    $error("AEMPTY_THRESH out of range 0..DEPTH-1");
  end
  if (FWFT > FIFO_MODE_FWFT) begin : g_chk_mode
    $error("FWFT must be 0 or 1");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  rd_ok, wr_ok, ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign Full         = (count_q == CntFull);
  assign Empty        = (count_q == '0);
  assign Almost_Full  = (count_q >= AfullThr);
  assign Almost_Empty = (count_q <= AemptThr);
  assign Count        = count_q;
  assign OverFlow     = ovf_q;
  assign UnderFlow    = udf_q;

  // A full FIFO still accepts a write when the same edge pops a word.
  assign rd_ok  = Read_EN & ~Empty;
  assign wr_ok  = Write_EN & (~Full | rd_ok);
  assign ram_we = wr_ok & rst_n & ~Flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      ovf_d = Write_EN & ~wr_ok;
      udf_d = Read_EN & ~rd_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_ptr_q),
    .wdata(Data_IN),
    .raddr(rd_ptr_q),
    .rdata(ram_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign Data_OUT = Empty ? '0 : ram_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (rd_ok && !Flush) begin
        dout_q <= ram_rdata;
      end
    end
    assign Data_OUT = dout_q;
  end

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and checks both against a
// queue-based reference model.
module tb_fifo_sync_prog;

  logic       clk = 1'b0;
  logic       rst_n, flush, we, re;
  logic [7:0] din;

  logic [7:0] d_s, d_f;
  logic [5:0] c_s, c_f;
  logic       full_s, empty_s, af_s, ae_s, of_s, uf_s;
  logic       full_f, empty_f, af_f, ae_f, of_f, uf_f;

  int vectors = 0;
  int miscompares = 0;

  bit [7:0] q[$];
  bit [7:0] m_dstd;
  bit       m_ovf, m_udf;

  always #5 clk = ~clk;

  fifo_sync_prog #(
    .DATA_WIDTH(8), .ADDR_WIDTH(5), .FWFT(0), .AFULL_THRESH(28), .AEMPTY_THRESH(4)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .Flush(flush), .Write_EN(we), .Data_IN(din), .Read_EN(re),
    .Data_OUT(d_s), .Count(c_s), .Full(full_s), .Empty(empty_s), .Almost_Full(af_s),
    .Almost_Empty(ae_s), .OverFlow(of_s), .UnderFlow(uf_s)
  );

  fifo_sync_prog #(
    .DATA_WIDTH(8), .ADDR_WIDTH(5), .FWFT(1), .AFULL_THRESH(28), .AEMPTY_THRESH(4)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .Flush(flush), .Write_EN(we), .Data_IN(din), .Read_EN(re),
    .Data_OUT(d_f), .Count(c_f), .Full(full_f), .Empty(empty_f), .Almost_Full(af_f),
    .Almost_Empty(ae_f), .OverFlow(of_f), .UnderFlow(uf_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge, from the acceptance rules.
  task automatic model_edge(input bit r, input bit f, input bit w, input bit rd, input bit [7:0] d);
    bit full, empty, rd_ok, wr_ok;
    if (!r) begin
      q.delete();
      m_dstd = 8'h00;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else if (f) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      full  = (q.size() == 32);
      empty = (q.size() == 0);
      rd_ok = rd && !empty;
      wr_ok = w && (!full || rd_ok);
      if (rd_ok) m_dstd = q.pop_front();
      if (wr_ok) q.push_back(d);
      m_ovf = w && !wr_ok;
      m_udf = rd && !rd_ok;
    end
  endtask

  task automatic check_all();
    int n;
    logic [7:0] head;
    n    = q.size();
    head = (n != 0) ? q[0] : 8'h00;
    chk("std.count",  32'(c_s), 32'(n));
    chk("fwft.count", 32'(c_f), 32'(n));
    chk("std.full",   32'(full_s),  32'(n == 32));
    chk("fwft.full",  32'(full_f),  32'(n == 32));
    chk("std.empty",  32'(empty_s), 32'(n == 0));
    chk("fwft.empty", 32'(empty_f), 32'(n == 0));
    chk("std.afull",  32'(af_s), 32'(n >= 28));
    chk("fwft.afull", 32'(af_f), 32'(n >= 28));
    chk("std.aempty", 32'(ae_s), 32'(n <= 4));
    chk("fwft.aempty", 32'(ae_f), 32'(n <= 4));
    chk("std.ovf",    32'(of_s), 32'(m_ovf));
    chk("fwft.ovf",   32'(of_f), 32'(m_ovf));
    chk("std.udf",    32'(uf_s), 32'(m_udf));
    chk("fwft.udf",   32'(uf_f), 32'(m_udf));
    chk("std.dout",   32'(d_s), 32'(m_dstd));
    chk("fwft.dout",  32'(d_f), 32'(head));
  endtask

  task automatic step(input bit r, input bit f, input bit w, input bit rd, input bit [7:0] d);
    rst_n = r;
    flush = f;
    we    = w;
    re    = rd;
    din   = d;
    @(posedge clk);
    model_edge(r, f, w, rd, d);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; we = 1'b0; re = 1'b0; din = 8'h00;

    // Reset, then fill 1..32 through every flag threshold.
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 32; i++) step(1, 0, 1, 0, 8'(i));

    // Writes into a full FIFO are rejected with a pulse per attempt.
    step(1, 0, 1, 0, 8'hFF);
    step(1, 0, 1, 0, 8'hFF);
    step(1, 0, 0, 0, 8'h00);
    chk("dir.full_count", 32'(c_s), 32'd32);

    // Drain, then one rejected pop.
    for (int i = 0; i < 32; i++) step(1, 0, 0, 1, 8'h00);
    step(1, 0, 0, 1, 8'h00);
    chk("dir.underflow", 32'(uf_s), 32'd1);
    step(1, 0, 0, 0, 8'h00);

    // Simultaneous read/write on a full FIFO.
    for (int i = 1; i <= 32; i++) step(1, 0, 1, 0, 8'(i + 100));
    step(1, 0, 1, 1, 8'hAA);
    for (int i = 0; i < 32; i++) step(1, 0, 0, 1, 8'h00);
    chk("dir.last_word", 32'(d_s), 32'hAA);

    // Simultaneous read/write on an empty FIFO: read rejected, write kept.
    step(1, 0, 1, 1, 8'h5A);
    chk("dir.fwft_5a", 32'(d_f), 32'h5A);
    step(1, 0, 0, 1, 8'h00);

    // Pointer wrap, then flush and mid-burst reset.
    for (int i = 0; i < 40; i++) step(1, 0, 1, (i % 2) == 1, 8'(i + 200));
    step(1, 1, 1, 0, 8'h77);
    chk("dir.flush_empty", 32'(empty_f), 32'd1);
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 8'(i + 50));
    step(0, 0, 1, 1, 8'h33);
    step(1, 0, 0, 0, 8'h00);

    // Randomised traffic: write-heavy, then read-heavy, with rare flush and reset.
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = (i < 300) ? 70 : 35;
      step($urandom_range(199) != 0, $urandom_range(79) == 0, $urandom_range(99) < wp,
           $urandom_range(99) < (100 - wp), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
